// File: rtl/alu_cmd_ctrl.sv
// Command sequencer between the UART byte stream and the ALU: parses operand and
// function bytes, fires the ALU once, then returns the 16-bit result LSB-first.
`timescale 1ns/1ps
module alu_cmd_ctrl #(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_W-1:0] CMD_ALU_NOP = 8'hDD,
  parameter int                TIMEOUT     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   rxData,
  input  logic                rxValid,
  output logic [DATA_W-1:0]   aluOpA,
  output logic [DATA_W-1:0]   aluOpB,
  output logic [3:0]          aluFunc,
  output logic                aluEn,
  input  logic [2*DATA_W-1:0] aluOut,
  input  logic                aluOutValid,
  output logic [DATA_W-1:0]   txData,
  output logic                txValid,
  input  logic                txBusy,
  output logic                cmdErr
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUNC, ALU_EXEC, WAIT_RES, SEND_LO, SEND_HI
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]   aluOpA_q, aluOpA_d;
  logic [DATA_W-1:0]   aluOpB_q, aluOpB_d;
  logic [3:0]          aluFunc_q, aluFunc_d;
  logic                aluEn_q, aluEn_d;
  logic [DATA_W-1:0]   txData_q, txData_d;
  logic                txValid_q, txValid_d;
  logic                cmdErr_q, cmdErr_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]    tcnt_q, tcnt_d;

  logic             func_ok;
  logic             tx_ready;
  logic [CNT_W-1:0] tcnt_inc;
  logic             timeout_hit;

  assign func_ok     = (rxData[DATA_W-1:4] == '0);
  // The strobe cycle itself blocks the next send, so txValid never repeats back-to-back.
  assign tx_ready    = !txBusy && !txValid_q;
  assign tcnt_inc    = tcnt_q + 1'b1;
  assign timeout_hit = (tcnt_inc == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rxValid && rxData == CMD_ALU_OP)       state_d = GET_A;
        else if (rxValid && rxData == CMD_ALU_NOP) state_d = GET_FUNC;
      end
      GET_A:    if (rxValid) state_d = GET_B;
      GET_B:    if (rxValid) state_d = GET_FUNC;
      GET_FUNC: if (rxValid) state_d = func_ok ? ALU_EXEC : IDLE;
      ALU_EXEC: state_d = WAIT_RES;
      WAIT_RES: begin
        if (aluOutValid)      state_d = SEND_LO;
        else if (timeout_hit) state_d = IDLE;
      end
      SEND_LO:  if (tx_ready) state_d = SEND_HI;
      SEND_HI:  if (tx_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    aluOpA_d  = aluOpA_q;
    aluOpB_d  = aluOpB_q;
    aluFunc_d = aluFunc_q;
    aluEn_d   = 1'b0;
    txData_d  = txData_q;
    txValid_d = 1'b0;
    cmdErr_d  = 1'b0;
    result_d  = result_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      IDLE: begin
        if (rxValid && rxData != CMD_ALU_OP && rxData != CMD_ALU_NOP) cmdErr_d = 1'b1;
      end
      GET_A: if (rxValid) aluOpA_d = rxData;
      GET_B: if (rxValid) aluOpB_d = rxData;
      GET_FUNC: begin
        if (rxValid) begin
          if (func_ok) begin
            aluFunc_d = rxData[3:0];
            aluEn_d   = 1'b1;
          end else begin
            cmdErr_d  = 1'b1;
          end
        end
      end
      ALU_EXEC: tcnt_d = '0;
      WAIT_RES: begin
        if (aluOutValid) begin
          result_d = aluOut;
        end else begin
          tcnt_d = tcnt_inc;
          if (timeout_hit) cmdErr_d = 1'b1;
        end
      end
      SEND_LO: begin
        if (tx_ready) begin
          txData_d  = result_q[DATA_W-1:0];
          txValid_d = 1'b1;
        end
      end
      SEND_HI: begin
        if (tx_ready) begin
          txData_d  = result_q[2*DATA_W-1:DATA_W];
          txValid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluOpA_q  <= '0;
      aluOpB_q  <= '0;
      aluFunc_q <= '0;
      aluEn_q   <= 1'b0;
      txData_q  <= '0;
      txValid_q <= 1'b0;
      cmdErr_q  <= 1'b0;
      result_q  <= '0;
      tcnt_q    <= '0;
    end else begin
      aluOpA_q  <= aluOpA_d;
      aluOpB_q  <= aluOpB_d;
      aluFunc_q <= aluFunc_d;
      aluEn_q   <= aluEn_d;
      txData_q  <= txData_d;
      txValid_q <= txValid_d;
      cmdErr_q  <= cmdErr_d;
      result_q  <= result_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign aluOpA  = aluOpA_q;
  assign aluOpB  = aluOpB_q;
  assign aluFunc = aluFunc_q;
  assign aluEn   = aluEn_q;
  assign txData  = txData_q;
  assign txValid = txValid_q;
  assign cmdErr  = cmdErr_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: table of command frames plus hand-written
// sequences for txBusy back-pressure, result timeout and asynchronous reset.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] rxData;
  logic              rxValid;
  logic [DATA_W-1:0] aluOpA, aluOpB;
  logic [3:0]        aluFunc;
  logic              aluEn;
  logic [15:0]       aluOut;
  logic              aluOutValid;
  logic [DATA_W-1:0] txData;
  logic              txValid;
  logic              txBusy;
  logic              cmdErr;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.DATA_W(DATA_W), .CMD_ALU_OP(8'hCC), .CMD_ALU_NOP(8'hDD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid),
    .aluOpA(aluOpA), .aluOpB(aluOpB), .aluFunc(aluFunc), .aluEn(aluEn),
    .aluOut(aluOut), .aluOutValid(aluOutValid),
    .txData(txData), .txValid(txValid), .txBusy(txBusy), .cmdErr(cmdErr)
  );

  typedef struct {
    logic [31:0] bytes;   // first byte in [31:24]
    int          nb;
    int          dly;     // cycles from aluEn to aluOutValid, 0 = no response
    logic [15:0] res;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [3:0]  exp_f;
    int          exp_en;
    int          exp_err;
    int          exp_tx;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0, en_cnt = 0, err_cnt = 0, en_cyc = 0, err_cyc = 0;
  int b2b_viol = 0, overlap_viol = 0;
  logic prev_tx = 1'b0;
  logic [7:0] txq[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (aluEn) begin en_cnt++; en_cyc = cyc; end
    if (cmdErr) begin err_cnt++; err_cyc = cyc; end
    if (txValid) begin
      txq.push_back(txData);
      if (prev_tx) b2b_viol++;
    end
    if (aluEn && cmdErr) overlap_viol++;
    prev_tx = txValid;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_aluOpA"},  32'(aluOpA),  0);
    check({tag, "_aluOpB"},  32'(aluOpB),  0);
    check({tag, "_aluFunc"}, 32'(aluFunc), 0);
    check({tag, "_aluEn"},   32'(aluEn),   0);
    check({tag, "_txData"},  32'(txData),  0);
    check({tag, "_txValid"}, 32'(txValid), 0);
    check({tag, "_cmdErr"},  32'(cmdErr),  0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    rxData  = '0;
  endtask

  task automatic alu_respond(input logic [15:0] r);
    aluOut      = r;
    aluOutValid = 1'b1;
    @(negedge clk);
    aluOutValid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e0, r0;
    string p;
    p  = $sformatf("v%0d", idx);
    e0 = en_cnt;
    r0 = err_cnt;
    txq.delete();
    for (int i = 0; i < v.nb; i++) send_byte(v.bytes[31-8*i -: 8]);
    if (v.exp_en != 0)  check({p, "_aluEn_latency"},  32'(aluEn),  1);
    if (v.exp_err != 0) check({p, "_cmdErr_latency"}, 32'(cmdErr), 1);
    if (v.dly > 0) begin
      repeat (v.dly) @(negedge clk);
      alu_respond(v.res);
    end
    repeat (8) @(negedge clk);
    check({p, "_aluOpA"},  32'(aluOpA),  32'(v.exp_a));
    check({p, "_aluOpB"},  32'(aluOpB),  32'(v.exp_b));
    check({p, "_aluFunc"}, 32'(aluFunc), 32'(v.exp_f));
    check({p, "_en_pulses"},  32'(en_cnt - e0),  32'(v.exp_en));
    check({p, "_err_pulses"}, 32'(err_cnt - r0), 32'(v.exp_err));
    check({p, "_tx_count"},   32'(txq.size()),   32'(v.exp_tx));
    if (v.exp_tx == 2 && txq.size() == 2) begin
      check({p, "_tx_lo"}, 32'(txq[0]), 32'(v.exp_lo));
      check({p, "_tx_hi"}, 32'(txq[1]), 32'(v.exp_hi));
    end
  endtask

  vec_t vecs[8];
  vec_t post_vec;

  initial begin
    int e0, r0;

    vecs[0] = '{32'hCC050301, 4,  2, 16'h0123, 8'h05, 8'h03, 4'h1, 1, 0, 2, 8'h23, 8'h01};
    vecs[1] = '{32'hDD0C0000, 2,  2, 16'hBEEF, 8'h05, 8'h03, 4'hC, 1, 0, 2, 8'hEF, 8'hBE};
    vecs[2] = '{32'hCC010235, 4,  0, 16'h0000, 8'h01, 8'h02, 4'hC, 0, 1, 0, 8'h00, 8'h00};
    vecs[3] = '{32'h7A000000, 1,  0, 16'h0000, 8'h01, 8'h02, 4'hC, 0, 1, 0, 8'h00, 8'h00};
    vecs[4] = '{32'hCCFF800F, 4,  1, 16'h8001, 8'hFF, 8'h80, 4'hF, 1, 0, 2, 8'h01, 8'h80};
    vecs[5] = '{32'hDD000000, 2, 15, 16'hA55A, 8'hFF, 8'h80, 4'h0, 1, 0, 2, 8'h5A, 8'hA5};
    vecs[6] = '{32'hDD100000, 2,  0, 16'h0000, 8'hFF, 8'h80, 4'h0, 0, 1, 0, 8'h00, 8'h00};
    vecs[7] = '{32'hCC00000A, 4,  3, 16'hFFFF, 8'h00, 8'h00, 4'hA, 1, 0, 2, 8'hFF, 8'hFF};
    post_vec = '{32'hDD000000, 2, 2, 16'h1357, 8'h00, 8'h00, 4'h0, 1, 0, 2, 8'h57, 8'h13};

    rst = 1'b1; rxData = '0; rxValid = 1'b0;
    aluOut = '0; aluOutValid = 1'b0; txBusy = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // txBusy held at SEND_LO with a stray byte arriving during the wait
    e0 = en_cnt; r0 = err_cnt; txq.delete();
    send_byte(8'hCC); send_byte(8'h11); send_byte(8'h22); send_byte(8'h03);
    check("busy_aluEn_latency", 32'(aluEn), 1);
    txBusy = 1'b1;
    repeat (2) @(negedge clk);
    alu_respond(16'h1234);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send_byte(8'hCC);
      else        @(negedge clk);
    end
    check("busy_no_tx_while_busy", 32'(txq.size()), 0);
    txBusy = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_tx_count", 32'(txq.size()), 2);
    if (txq.size() == 2) begin
      check("busy_tx_lo", 32'(txq[0]), 32'h34);
      check("busy_tx_hi", 32'(txq[1]), 32'h12);
    end
    check("busy_err_pulses", 32'(err_cnt - r0), 0);
    check("busy_en_pulses",  32'(en_cnt - e0),  1);

    // result never arrives: abort after TIMEOUT-1 cycles in WAIT_RES
    e0 = en_cnt; r0 = err_cnt; txq.delete();
    send_byte(8'hDD); send_byte(8'h05);
    check("tmo_aluEn_latency", 32'(aluEn), 1);
    repeat (TIMEOUT + 4) @(negedge clk);
    check("tmo_err_pulses", 32'(err_cnt - r0), 1);
    check("tmo_err_timing", 32'(err_cyc - en_cyc), 32'(TIMEOUT));
    check("tmo_no_tx", 32'(txq.size()), 0);
    check("tmo_aluFunc", 32'(aluFunc), 32'h5);
    alu_respond(16'hFFFF);
    repeat (8) @(negedge clk);
    check("stray_result_no_tx", 32'(txq.size()), 0);
    check("stray_result_en", 32'(en_cnt - e0), 1);
    run_vec(vecs[0], 100);

    // asynchronous reset between clock edges after the GET_B byte
    send_byte(8'hCC); send_byte(8'hAA); send_byte(8'hBB);
    check("pre_rst_aluOpB", 32'(aluOpB), 32'hBB);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(post_vec, 200);

    check("tx_back_to_back", 32'(b2b_viol), 0);
    check("en_err_overlap",  32'(overlap_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command-sequencing controller that sits directly upstream of the ALU and its function decoder. It parses operand and function bytes from the UART RX byte stream and drives registered operands, a 4-bit function code and a one-cycle enable into the ALU. It then captures the 16-bit ALU result and returns it LSB-first to the UART TX path using a busy/valid handshake.

Parameters:
DATA_W, 8, width of RX/TX bytes and of each ALU operand
CMD_ALU_OP, 8'hCC, command byte: new operands + function
CMD_ALU_NOP, 8'hDD, command byte: reuse held operands, function only
TIMEOUT, 16, max cycles in WAIT_RES before abort (must be >= 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
rxData  input  DATA_W  received byte
rxValid  input  1  one-cycle strobe, rxData valid
aluOpA  output  DATA_W  operand A, registered, held between commands
aluOpB  output  DATA_W  operand B, registered, held between commands
aluFunc  output  4  [3:2] unit select to decoder, [1:0] op within unit
aluEn  output  1  one-cycle ALU start pulse
aluOut  input  2*DATA_W  ALU result
aluOutValid  input  1  one-cycle strobe, aluOut valid
txData  output  DATA_W  byte to transmitter
txValid  output  1  one-cycle strobe, txData valid
txBusy  input  1  transmitter cannot accept a byte
cmdErr  output  1  one-cycle error pulse

Behaviour:
- Reset (async, rst=1): state IDLE; aluOpA=0, aluOpB=0, aluFunc=0, aluEn=0, txData=0, txValid=0, cmdErr=0, result reg=0, timeout counter=0.
- All outputs registered; state advances only on rising clk.
- States: IDLE, GET_A, GET_B, GET_FUNC, ALU_EXEC, WAIT_RES, SEND_LO, SEND_HI.
- IDLE:
  - rxValid & rxData==CMD_ALU_OP -> GET_A.
  - rxValid & rxData==CMD_ALU_NOP -> GET_FUNC.
  - rxValid with any other byte -> cmdErr pulse next cycle, stay IDLE.
- GET_A: on rxValid, latch aluOpA, go to GET_B.
- GET_B: on rxValid, latch aluOpB, go to GET_FUNC.
- GET_FUNC: on rxValid:
  - If rxData[7:4]!=0: cmdErr pulse, go to IDLE. aluFunc and operands already latched in this frame keep their values.
  - Otherwise latch aluFunc=rxData[3:0] and go to ALU_EXEC.
- ALU_EXEC: aluEn=1 for exactly one cycle; clear timeout counter; go to WAIT_RES. aluEn is high in the cycle after the function byte's rxValid (1-cycle latency from the registered aluFunc).
- WAIT_RES:
  - aluOutValid -> capture aluOut into result reg, go to SEND_LO. aluOutValid is accepted in the first WAIT_RES cycle.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without aluOutValid: cmdErr pulse, go to IDLE, no TX.
- aluOutValid outside WAIT_RES: ignored.
- SEND_LO:
  - If txBusy==0: txData=result[DATA_W-1:0], txValid=1 for one cycle, go to SEND_HI.
  - If txBusy==1: wait, txValid=0.
- SEND_HI: same rule with result[2*DATA_W-1:DATA_W], then go to IDLE.
- txValid is never asserted in back-to-back cycles. SEND_HI samples txBusy in the cycle after the LO strobe.
- rxValid in ALU_EXEC, WAIT_RES, SEND_LO or SEND_HI: byte dropped, no error, no state change.
- Mid-frame reset returns to IDLE and clears all outputs. There is no partial-frame recovery.
- cmdErr and aluEn are never high in the same cycle.

Test Plan:
- Frame CC,05,03,01 with ALU returning 16'h0123 two cycles after aluEn -> aluOpA=05, aluOpB=03, aluFunc=1; aluEn pulses once, 1 cycle after the last rxValid; txData 23 then 01, each with a single txValid pulse.
- After the previous frame, send DD,0C with result 16'hBEEF -> operands remain 05/03, aluFunc=C; TX sends EF then BE.
- Send CC,01,02,35 -> cmdErr pulse, aluEn never asserts, state back to IDLE; then send 7A -> second cmdErr pulse; no TX.
- Hold txBusy=1 for 10 cycles at SEND_LO, insert an rxValid during the wait, then release -> txValid only after release; the extra byte is dropped; LO/HI order is preserved.
- aluOutValid withheld -> cmdErr pulse TIMEOUT-1 cycles after entering WAIT_RES, no txValid; the next valid frame executes normally.
- Assert rst asynchronously after the GET_B byte (between clk edges) -> all outputs 0 immediately; a following DD,00 frame executes with operands 00/00.
